lipsi_dmem_arbiter: RTL and testbench
=====================================

// Module: lipsi_dmem_arbiter
// PURPOSE
//   Shares the 256x8 Lipsi data memory between the processor core (cpu port) and a
//   host/loader port (host port). Single-port RAM behind a 2-way arbiter with per-port
//   req/gnt/rvalid handshake and an optional bus lock for read-modify-write sequences.
//   Sits between lipsi_processor data accesses and the board-level loader/debug logic.
// PARAMETERS
//   ADDR_W    8   address width; RAM depth = 2**ADDR_W, fully decoded, no aliasing
//   DATA_W    8   data width
//   MAX_LOCK  16  max consecutive locked grants to one port before forced release (>=1)
// PORTS
//   clk          in   1       system clock, single clock domain
//   reset        in   1       synchronous, active-high
//   cpu_req      in   1       cpu access request, held until granted
//   cpu_we       in   1       1 = write, 0 = read
//   cpu_lock     in   1       keep ownership after this grant
//   cpu_addr     in   ADDR_W  access address
//   cpu_wdata    in   DATA_W  write data
//   cpu_gnt      out  1       access accepted this cycle
//   cpu_rvalid   out  1       read data valid (1 cycle after read grant)
//   cpu_rdata    out  DATA_W  read data
//   host_*       same set as cpu_* for the host port
//   lock_err     out  1       1-cycle pulse when a lock is force-released
// BEHAVIOUR
//   - Reset: owner=NONE, lock counter=0, all gnt/rvalid/lock_err=0, rdata=0; RAM contents
//     not cleared. Reset mid-read: rvalid of the pending read is suppressed.
//   - State (owner): NONE, CPU, HOST. gnt_x combinational from req_x, owner, priority;
//     at most one gnt per cycle; gnt forced 0 while reset=1.
//   - Access commits at the clock edge ending the gnt cycle. Read: rdata_x/rvalid_x
//     registered, valid exactly 1 cycle later; rdata holds until next read by same port.
//   - Write then read same address on consecutive grants (either port) returns new data.
//   - NONE: grant by priority; granted port with lock=1 -> owner=that port, else NONE.
//   - CPU/HOST (locked): only owner can be granted; other port stalls (gnt=0, req held).
//     Owner drops lock on a granted cycle, or deasserts req, -> owner=NONE next cycle.
//   - Lock counter counts consecutive locked grants; on MAX_LOCK-th grant owner forced to
//     NONE, counter=0, lock_err pulses next cycle; the other port wins the next tie.
//   - No req on either port: idle, no RAM access, state unchanged except as above.
//   - Priority without macro: fixed, cpu beats host on simultaneous req.
// CONFIGURATION
//   LIPSI_ARB_RR_EN defined: round-robin tie-break; port not granted most recently wins
//     a simultaneous request (last-winner register reset to HOST so cpu wins first tie).
//   LIPSI_ARB_RR_EN undefined: fixed cpu priority; no last-winner register.
// STRUCTURE
//   lipsi_pkg: owner_e enum {OWN_NONE, OWN_CPU, OWN_HOST}, LIPSI_ADDR_W=8, LIPSI_DATA_W=8.
//   Sub-module lipsi_dmem: single-port sync RAM (we, addr, wdata, registered rdata).
//   Arbiter FSM, lock counter, rvalid routing stay in lipsi_dmem_arbiter.
// TESTING
//   1. Reset, host writes 0x3C to 0x10, cpu reads 0x10 -> cpu_rvalid 1 cycle after gnt,
//      cpu_rdata=0x3C.
//   2. Both req same cycle (no macro) -> cpu_gnt=1, host_gnt=0; host granted next cycle.
//   3. LIPSI_ARB_RR_EN, both req continuously 6 cycles -> grants alternate C,H,C,H,C,H.
//   4. cpu lock for 3 grants (read 0x20, write 0x21, read 0x21) while host req held ->
//      host_gnt=0 for 3 cycles, then host granted; cpu read of 0x21 returns written value.
//   5. host lock held forever, cpu req held, MAX_LOCK=16 -> 16 host grants, lock_err
//      pulses once, next grant goes to cpu.
//   6. reset asserted the cycle after a cpu read grant -> cpu_rvalid stays 0, owner=NONE.

Source files
------------

// File: rtl/lipsi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lipsi_pkg                                                    |
// | Description : Shared types and sizes for the Lipsi data-memory subsystem.  |
// |               owner_e encodes which port currently holds the bus lock.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package lipsi_pkg;

    localparam int LIPSI_ADDR_W = 8;
    localparam int LIPSI_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/lipsi_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lipsi_dmem                                                   |
// | Description : Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered  |
// |               read data. Contents are never cleared.                       |
// | Ports       : clk   - clock                                                |
// |               en    - access enable (no access when low)                   |
// |               we    - 1 = write, 0 = read                                  |
// |               addr  - address                                              |
// |               wdata - write data                                           |
// |               rdata - read data, valid the cycle after a read access       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lipsi_dmem
    import lipsi_pkg::*;
#(
    parameter int ADDR_W = LIPSI_ADDR_W,
    parameter int DATA_W = LIPSI_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lipsi_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lipsi_dmem_arbiter                                           |
// | Description : Two-port (cpu / host) arbiter in front of the Lipsi data     |
// |               RAM. Per-port req/gnt/rvalid handshake, optional bus lock    |
// |               for read-modify-write, lock watchdog after MAX_LOCK grants.  |
// | Config      : LIPSI_ARB_RR_EN defined   -> round-robin tie-break           |
// |               LIPSI_ARB_RR_EN undefined -> fixed cpu priority              |
// | Ports       : clk, reset (sync, active-high)                               |
// |               cpu_req/we/lock/addr/wdata  -> cpu_gnt/rvalid/rdata          |
// |               host_req/we/lock/addr/wdata -> host_gnt/rvalid/rdata         |
// |               lock_err - 1-cycle pulse after a forced lock release         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lipsi_dmem_arbiter
    import lipsi_pkg::*;
#(
    parameter int ADDR_W   = LIPSI_ADDR_W,
    parameter int DATA_W   = LIPSI_DATA_W,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              lock_err
);

    localparam int                 c_CNT_W    = $clog2(MAX_LOCK + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_LOCK = c_CNT_W'(MAX_LOCK);

    owner_e             r_owner;
    owner_e             w_owner_nxt;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_lock_cnt_nxt;
    logic [c_CNT_W-1:0] w_lock_cnt_inc;

    logic w_cpu_gnt;
    logic w_host_gnt;
    logic w_gnt_any;
    logic w_gnt_locked;
    logic w_force;
    logic w_tie;
    logic w_tie_host;

    logic              r_cpu_rvalid;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_host_hold;
    logic              r_lock_err;

    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_tie = cpu_req && host_req;

    // Tie-break selection: w_tie_host = 1 means host wins a simultaneous request
    // while nobody owns the bus.
`ifdef LIPSI_ARB_RR_EN
    logic r_last_host;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_host <= 1'b1;
        end else if (w_gnt_any) begin
            r_last_host <= w_host_gnt;
        end
    end

    assign w_tie_host = ~r_last_host;
`else
    // Fixed cpu priority, except that the tie directly following a forced release
    // of a cpu lock goes to the host so the starved port gets through.
    logic r_host_pref;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_pref <= 1'b0;
        end else if (w_force && w_cpu_gnt) begin
            r_host_pref <= 1'b1;
        end else if ((r_owner == OWN_NONE) && w_tie) begin
            r_host_pref <= 1'b0;
        end
    end

    assign w_tie_host = r_host_pref;
`endif

    // Grant decode: only the owner can be granted while the bus is locked.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!reset) begin
            case (r_owner)
                OWN_CPU:  w_cpu_gnt  = cpu_req;
                OWN_HOST: w_host_gnt = host_req;
                default: begin
                    if (w_tie) begin
                        w_host_gnt = w_tie_host;
                        w_cpu_gnt  = ~w_tie_host;
                    end else begin
                        w_cpu_gnt  = cpu_req;
                        w_host_gnt = host_req;
                    end
                end
            endcase
        end
    end

    assign w_gnt_any      = w_cpu_gnt | w_host_gnt;
    assign w_gnt_locked   = (w_cpu_gnt & cpu_lock) | (w_host_gnt & host_lock);
    assign w_lock_cnt_inc = r_lock_cnt + 1'b1;
    assign w_force        = w_gnt_locked && (w_lock_cnt_inc == c_MAX_LOCK);

    // Ownership next state. Any cycle that is not a locked grant returns the
    // bus to NONE (unlocked grant, owner dropped req, or already idle).
    always_comb begin
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_gnt_locked) begin
            if (w_force) begin
                w_owner_nxt    = OWN_NONE;
                w_lock_cnt_nxt = '0;
            end else begin
                w_owner_nxt    = w_cpu_gnt ? OWN_CPU : OWN_HOST;
                w_lock_cnt_nxt = w_lock_cnt_inc;
            end
        end else begin
            w_owner_nxt    = OWN_NONE;
            w_lock_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_NONE;
            r_lock_cnt <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // RAM port mux; at most one grant is active so the select is unambiguous.
    assign w_ram_we    = w_cpu_gnt ? cpu_we    : host_we;
    assign w_ram_addr  = w_cpu_gnt ? cpu_addr  : host_addr;
    assign w_ram_wdata = w_cpu_gnt ? cpu_wdata : host_wdata;

    lipsi_dmem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .en    (w_gnt_any),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // Read-valid routing. The shared RAM output register is overwritten by the
    // next access of either port, so each port keeps its own copy of its last
    // read result in a hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_cpu_hold    <= '0;
            r_host_hold   <= '0;
            r_lock_err    <= 1'b0;
        end else begin
            r_cpu_rvalid  <= w_cpu_gnt  & ~cpu_we;
            r_host_rvalid <= w_host_gnt & ~host_we;
            r_lock_err    <= w_force;
            if (r_cpu_rvalid) begin
                r_cpu_hold <= w_ram_rdata;
            end
            if (r_host_rvalid) begin
                r_host_hold <= w_ram_rdata;
            end
        end
    end

    // Outputs are masked during reset so a read granted just before reset
    // never reports valid data.
    assign cpu_gnt     = w_cpu_gnt;
    assign host_gnt    = w_host_gnt;
    assign cpu_rvalid  = r_cpu_rvalid  & ~reset;
    assign host_rvalid = r_host_rvalid & ~reset;
    assign lock_err    = r_lock_err    & ~reset;
    assign cpu_rdata   = reset ? '0 : (r_cpu_rvalid  ? w_ram_rdata : r_cpu_hold);
    assign host_rdata  = reset ? '0 : (r_host_rvalid ? w_ram_rdata : r_host_hold);

endmodule
`default_nettype wire

// File: tb/tb_lipsi_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lipsi_dmem_arbiter                                        |
// | Description : Self-checking bench for lipsi_dmem_arbiter. A behavioural    |
// |               model of ownership, grants, memory and read returns is       |
// |               compared against the DUT every cycle; directed scenarios pin |
// |               literal values. Honours LIPSI_ARB_RR_EN.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_lipsi_dmem_arbiter;

    localparam int MAX_LOCK = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_lock;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       host_req, host_we, host_lock;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       lock_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lipsi_dmem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_lock    (cpu_lock),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .lock_err    (lock_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int         m_owner;        // 0 none, 1 cpu, 2 host
    int         m_cnt;
    bit         m_last_host;
    bit         m_host_pref;
    bit         m_err;
    logic [7:0] mem  [256];
    bit         memv [256];
    bit         m_cpu_pend, m_cpu_pknown, m_cpu_hknown;
    bit         m_host_pend, m_host_pknown, m_host_hknown;
    logic [7:0] m_cpu_pdata, m_cpu_hold, m_host_pdata, m_host_hold;
    bit         e_cpu_gnt = 1'b0;
    bit         e_host_gnt = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) memv[i] = 1'b0;
    end

    always @(negedge clk) begin
        bit cg, hg, both, tie_host;
        if (reset) begin
            chk("rst_cpu_gnt", cpu_gnt, 0);
            chk("rst_host_gnt", host_gnt, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_host_rvalid", host_rvalid, 0);
            chk("rst_lock_err", lock_err, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_host_rdata", host_rdata, 0);
            m_owner = 0; m_cnt = 0; m_last_host = 1'b1; m_host_pref = 1'b0; m_err = 1'b0;
            m_cpu_pend = 1'b0; m_host_pend = 1'b0;
            m_cpu_hold = 8'h00; m_host_hold = 8'h00;
            m_cpu_hknown = 1'b1; m_host_hknown = 1'b1;
            e_cpu_gnt = 1'b0; e_host_gnt = 1'b0;
        end else begin
            cg = 1'b0; hg = 1'b0;
            both = cpu_req && host_req;
`ifdef LIPSI_ARB_RR_EN
            tie_host = !m_last_host;
`else
            tie_host = m_host_pref;
`endif
            if (m_owner == 1) cg = cpu_req;
            else if (m_owner == 2) hg = host_req;
            else if (both) begin
                if (tie_host) hg = 1'b1; else cg = 1'b1;
            end else begin
                cg = cpu_req; hg = host_req;
            end
            e_cpu_gnt = cg; e_host_gnt = hg;

            chk("cpu_gnt", cpu_gnt, cg);
            chk("host_gnt", host_gnt, hg);
            chk("cpu_rvalid", cpu_rvalid, m_cpu_pend);
            chk("host_rvalid", host_rvalid, m_host_pend);
            chk("lock_err", lock_err, m_err);
            if (m_cpu_pend ? m_cpu_pknown : m_cpu_hknown)
                chk("cpu_rdata", cpu_rdata, m_cpu_pend ? m_cpu_pdata : m_cpu_hold);
            if (m_host_pend ? m_host_pknown : m_host_hknown)
                chk("host_rdata", host_rdata, m_host_pend ? m_host_pdata : m_host_hold);

            // advance model to next cycle
            if (m_cpu_pend)  begin m_cpu_hold  = m_cpu_pdata;  m_cpu_hknown  = m_cpu_pknown;  end
            if (m_host_pend) begin m_host_hold = m_host_pdata; m_host_hknown = m_host_pknown; end
            m_cpu_pend = 1'b0; m_host_pend = 1'b0; m_err = 1'b0;
            if (cg) begin
                if (cpu_we) begin mem[cpu_addr] = cpu_wdata; memv[cpu_addr] = 1'b1; end
                else begin m_cpu_pend = 1'b1; m_cpu_pdata = mem[cpu_addr]; m_cpu_pknown = memv[cpu_addr]; end
            end
            if (hg) begin
                if (host_we) begin mem[host_addr] = host_wdata; memv[host_addr] = 1'b1; end
                else begin m_host_pend = 1'b1; m_host_pdata = mem[host_addr]; m_host_pknown = memv[host_addr]; end
            end
`ifndef LIPSI_ARB_RR_EN
            if (m_owner == 0 && both) m_host_pref = 1'b0;
`endif
            if ((cg && cpu_lock) || (hg && host_lock)) begin
                m_cnt++;
                if (m_cnt == MAX_LOCK) begin
                    m_owner = 0; m_cnt = 0; m_err = 1'b1;
`ifndef LIPSI_ARB_RR_EN
                    if (cg) m_host_pref = 1'b1;
`endif
                end else begin
                    m_owner = cg ? 1 : 2;
                end
            end else begin
                m_owner = 0; m_cnt = 0;
            end
            if (cg || hg) m_last_host = hg;
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick;  @(posedge clk); #1; endtask
    task automatic probe; @(negedge clk); #1; endtask

    task automatic idle;
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic do_reset;
        reset = 1; idle; tick; reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hcnt, errs;
        bit got_cpu;
        reset = 1; idle;
        probe;
        chk("t1_reset_gnt", cpu_gnt, 0);
        chk("t1_reset_rdata", cpu_rdata, 0);
        tick; tick; reset = 0;

        // 1: host write, cpu read back
        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'h3C;
        probe; chk("t1_host_gnt", host_gnt, 1); tick;
        host_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        probe; chk("t1_cpu_gnt", cpu_gnt, 1); chk("t1_rvalid_early", cpu_rvalid, 0); tick;
        cpu_req = 0;
        probe; chk("t1_cpu_rvalid", cpu_rvalid, 1); chk("t1_cpu_rdata", cpu_rdata, 8'h3C); tick;
        probe; chk("t1_rvalid_drop", cpu_rvalid, 0); chk("t1_rdata_hold", cpu_rdata, 8'h3C); tick;

`ifndef LIPSI_ARB_RR_EN
        // 2: simultaneous request, fixed priority
        do_reset;
        cpu_req = 1; host_req = 1; cpu_addr = 8'h10; host_addr = 8'h10;
        probe; chk("t2_cpu_gnt", cpu_gnt, 1); chk("t2_host_gnt", host_gnt, 0); tick;
        cpu_req = 0;
        probe; chk("t2_host_next", host_gnt, 1); tick;
        idle;
`else
        // 3: round-robin alternation
        do_reset;
        cpu_req = 1; host_req = 1;
        for (int i = 0; i < 6; i++) begin
            probe;
            chk("t3_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
            chk("t3_host_gnt", host_gnt, (i % 2 == 1) ? 1 : 0);
            tick;
        end
        idle;
`endif

        // 4: cpu locked read-modify-write while host waits
        do_reset;
        host_req = 1; host_we = 0; host_addr = 8'h21;
        cpu_req = 1; cpu_lock = 1; cpu_we = 0; cpu_addr = 8'h20;
        probe; chk("t4_c1_cpu", cpu_gnt, 1); chk("t4_c1_host", host_gnt, 0); tick;
        cpu_we = 1; cpu_addr = 8'h21; cpu_wdata = 8'hA5;
        probe; chk("t4_c2_cpu", cpu_gnt, 1); chk("t4_c2_host", host_gnt, 0); tick;
        cpu_we = 0; cpu_lock = 0;
        probe; chk("t4_c3_cpu", cpu_gnt, 1); chk("t4_c3_host", host_gnt, 0); tick;
        cpu_req = 0;
        probe; chk("t4_host_gnt", host_gnt, 1);
        chk("t4_cpu_rvalid", cpu_rvalid, 1); chk("t4_cpu_rdata", cpu_rdata, 8'hA5); tick;
        host_req = 0;
        probe; chk("t4_host_rdata", host_rdata, 8'hA5); tick;

        // 5: host lock watchdog
        do_reset;
        host_req = 1; host_lock = 1; host_addr = 8'h30;
        hcnt = 0; errs = 0; got_cpu = 0;
        for (int i = 0; i < 40; i++) begin
            probe;
            if (host_gnt) hcnt++;
            if (lock_err) errs++;
            if (cpu_gnt) begin got_cpu = 1; break; end
            tick;
            if (i == 0) begin cpu_req = 1; cpu_addr = 8'h31; end
        end
        chk("t5_cpu_granted", got_cpu, 1);
        chk("t5_host_grants", hcnt, MAX_LOCK);
        chk("t5_lock_err_pulses", errs, 1);
        tick; idle;

        // 6: reset right after a cpu read grant
        do_reset;
        cpu_req = 1; cpu_lock = 1; cpu_addr = 8'h10;
        probe; chk("t6_cpu_gnt", cpu_gnt, 1); tick;
        reset = 1; cpu_req = 0; cpu_lock = 0;
        probe; chk("t6_rvalid_in_rst", cpu_rvalid, 0); tick;
        reset = 0; host_req = 1; host_addr = 8'h11;
        probe; chk("t6_owner_none", host_gnt, 1); chk("t6_rvalid_after", cpu_rvalid, 0); tick;
        idle;

        // random traffic; a request is held until the model says it was granted
        for (int c = 0; c < 4000; c++) begin
            int lock_pct;
            lock_pct = (c < 2000) ? 30 : 95;
            reset = ($urandom_range(0, 249) == 0);
            if (!(cpu_req && !e_cpu_gnt)) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_lock  = ($urandom_range(0, 99) < lock_pct);
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (!(host_req && !e_host_gnt)) begin
                host_req   = ($urandom_range(0, 9) < 6);
                host_we    = $urandom_range(0, 1) == 1;
                host_lock  = ($urandom_range(0, 99) < lock_pct);
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
            tick;
        end
        reset = 0; idle; tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
